// File: rtl/ram_in_loader.sv
// ram_in_loader: byte stream to 32x8 input RAM frame loader.
// Pads short frames, starts the converter and waits for its done.
module ram_in_loader #(
  parameter int FRAME_BYTES  = 32,
  parameter int ADDR_W       = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ram_in_we,
  output logic [ADDR_W-1:0] ram_in_addr_wr,
  output logic [7:0]        ram_in_data_wr,
  output logic              opmode_out,
  input  logic              done_in,
  output logic              busy,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [2:0] {
    LOAD,
    PAD,
    FLUSH,
    START,
    WAIT_CLR,
    WAIT_DONE,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(FRAME_BYTES - 1);
  localparam logic [3:0] DRAIN_LAST =
    4'(DRAIN_CYCLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic [3:0]        drain_cnt;
  logic              run_q;
  logic              accept;
  logic              at_end;

  // run_q keeps s_ready low on the reset cycles themselves
  assign s_ready = run_q && (state == LOAD);
  assign accept  = s_valid && s_ready;
  assign at_end  = (idx == LAST_IDX);
  assign idx_nxt = at_end ? '0 : idx + ADDR_W'(1);

  // Frame sequencer with registered RAM port and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD;
      idx            <= '0;
      drain_cnt      <= '0;
      run_q          <= 1'b0;
      ram_in_we      <= 1'b0;
      ram_in_addr_wr <= '0;
      ram_in_data_wr <= '0;
      opmode_out     <= 1'b0;
      busy           <= 1'b0;
      frame_err      <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      run_q      <= 1'b1;
      ram_in_we  <= 1'b0;
      opmode_out <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        LOAD: begin
          if (accept) begin
            ram_in_we      <= 1'b1;
            ram_in_addr_wr <= idx;
            ram_in_data_wr <= s_data;
            idx            <= idx_nxt;
            busy           <= 1'b1;
            if (at_end) begin
              state     <= FLUSH;
              frame_err <= !s_last;
            end else if (s_last) begin
              state     <= PAD;
              frame_err <= 1'b1;
            end
          end
        end
        PAD: begin
          ram_in_we      <= 1'b1;
          ram_in_addr_wr <= idx;
          ram_in_data_wr <= 8'h00;
          idx            <= idx_nxt;
          if (at_end) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          opmode_out <= 1'b1;
          state      <= START;
        end
        START: begin
          state <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!done_in) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done_in) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= LOAD;
            idx       <= '0;
            busy      <= 1'b0;
            drain_cnt <= '0;
            frame_cnt <= frame_cnt + CNT_W'(1);
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_in_loader.sv
// tb_ram_in_loader: scoreboard bench for ram_in_loader.
// Driver queues expected RAM writes; monitor pops on ram_in_we.
module tb_ram_in_loader;

  localparam int FB = 32;
  localparam int AW = 5;
  localparam int DC = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;
  logic          ram_in_we;
  logic [AW-1:0] ram_in_addr_wr;
  logic [7:0]    ram_in_data_wr;
  logic          opmode_out;
  logic          done_in;
  logic          busy;
  logic          frame_err;
  logic [CW-1:0] frame_cnt;

  always #5 clk = ~clk;

  ram_in_loader #(
    .FRAME_BYTES(FB),
    .ADDR_W(AW),
    .DRAIN_CYCLES(DC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .ram_in_we(ram_in_we),
    .ram_in_addr_wr(ram_in_addr_wr),
    .ram_in_data_wr(ram_in_data_wr),
    .opmode_out(opmode_out),
    .done_in(done_in),
    .busy(busy),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int wr_cnt = 0;
  int acc_edge = 0;
  int gap_bad = 0;
  logic [12:0] exp_q[$];
  int op_edges[$];
  int err_edges[$];
  logic [AW-1:0] exp_addr;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, expv);
    end
  endtask

  // monitor: edge counter, event capture, write scoreboard
  initial begin
    logic [12:0] e;
    forever begin
      @(posedge clk);
      ecnt++;
      #1;
      if (opmode_out) op_edges.push_back(ecnt);
      if (frame_err) err_edges.push_back(ecnt);
      if (ram_in_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(ram_in_addr_wr), 32'(e[12:8]));
          chk("wr_data", 32'(ram_in_data_wr), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic put_byte(input logic [7:0] d,
                          input logic l);
    int t;
    t = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!s_ready) begin
      chk("accept_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    exp_q.push_back({exp_addr, d});
    exp_addr = exp_addr + 5'd1;
    acc_edge = ecnt + 1;
    @(posedge clk);
  endtask

  task automatic send_frame(input int n,
                            input logic [7:0] base,
                            input bit last,
                            input bit gap);
    for (int i = 0; i < n; i++) begin
      put_byte(base + 8'(i), last && (i == n - 1));
      if (i == n - 1 && last && n < FB) begin
        for (int a = n; a < FB; a++)
          exp_q.push_back({5'(a), 8'h00});
        exp_addr = '0;
      end
      if (gap && i < n - 1) begin
        @(negedge clk);
        s_valid = 1'b0;
        if (!s_ready) gap_bad++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_start(input int n_op,
                             input int n_err,
                             input int exp_edge,
                             input int exp_err,
                             input int exp_err_edge);
    int t;
    t = 0;
    while (op_edges.size() == n_op && t < 100) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (op_edges.size() == n_op) begin
      chk("start_timeout", 0, 1);
    end else begin
      chk("start_edge", op_edges[n_op], exp_edge);
    end
    repeat (2) @(posedge clk);
    #2;
    chk("start_count", op_edges.size() - n_op, 1);
    chk("err_count", err_edges.size() - n_err, exp_err);
    if (exp_err > 0 && err_edges.size() > n_err)
      chk("err_edge", err_edges[n_err], exp_err_edge);
  endtask

  task automatic finish_frame(input int exp_cnt,
                              input int low_cyc);
    @(negedge clk);
    done_in = 1'b0;
    repeat (low_cyc) @(negedge clk);
    done_in = 1'b1;
    @(posedge clk);
    repeat (DC - 1) @(posedge clk);
    #2;
    chk("drain_hold", s_ready, 0);
    @(posedge clk);
    #2;
    chk("ready_after_drain", s_ready, 1);
    chk("frame_cnt", frame_cnt, exp_cnt);
    chk("busy_after_drain", busy, 0);
  endtask

  initial begin
    int n_op, n_err, w0, bad;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    s_last   = 1'b0;
    done_in  = 1'b0;
    exp_addr = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", s_ready, 0);
    chk("rst_we", ram_in_we, 0);
    chk("rst_op", opmode_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("ready_after_rst", s_ready, 1);

    // frame 1: full frame 0x00..0x1F
    n_op = op_edges.size();
    n_err = err_edges.size();
    w0 = wr_cnt;
    send_frame(32, 8'h00, 1'b1, 1'b0);
    chk("busy_loaded", busy, 1);
    check_start(n_op, n_err, acc_edge + 1, 0, 0);
    chk("f1_writes", wr_cnt - w0, 32);
    finish_frame(1, 70);

    // frame 2: short frame with stale done held high
    n_op = op_edges.size();
    n_err = err_edges.size();
    send_frame(5, 8'hA1, 1'b1, 1'b0);
    bad = 0;
    for (int j = 0; j < 27; j++) begin
      @(posedge clk);
      #2;
      if (!ram_in_we || s_ready ||
          ram_in_addr_wr != 5'(5 + j)) bad++;
    end
    chk("pad_run", bad, 0);
    check_start(n_op, n_err, acc_edge + 28, 1, acc_edge);
    repeat (10) @(posedge clk);
    #2;
    chk("wait_clr_ready", s_ready, 0);
    chk("wait_clr_busy", busy, 1);
    chk("wait_clr_cnt", frame_cnt, 1);
    finish_frame(2, 3);

    // frame 3: overlong frame, no s_last
    n_op = op_edges.size();
    n_err = err_edges.size();
    w0 = wr_cnt;
    send_frame(32, 8'hC0, 1'b0, 1'b0);
    check_start(n_op, n_err, acc_edge + 1, 1, acc_edge);
    chk("f3_writes", wr_cnt - w0, 32);
    finish_frame(3, 2);

    // frame 4: throttled input
    n_op = op_edges.size();
    n_err = err_edges.size();
    w0 = wr_cnt;
    gap_bad = 0;
    send_frame(32, 8'h40, 1'b1, 1'b1);
    chk("throttle_ready", gap_bad, 0);
    check_start(n_op, n_err, acc_edge + 1, 0, 0);
    chk("f4_writes", wr_cnt - w0, 32);
    finish_frame(4, 2);

    // reset after 10 accepts
    for (int i = 0; i < 10; i++)
      put_byte(8'h60 + 8'(i), 1'b0);
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    done_in = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_we", ram_in_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_op", opmode_out, 0);
    chk("mid_rst_err", frame_err, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_pending", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_addr = '0;
    @(posedge clk);
    #2;
    chk("mid_rst_release", s_ready, 1);
    n_op = op_edges.size();
    n_err = err_edges.size();
    w0 = wr_cnt;
    send_frame(32, 8'h80, 1'b1, 1'b0);
    check_start(n_op, n_err, acc_edge + 1, 0, 0);
    chk("f5_writes", wr_cnt - w0, 32);
    finish_frame(1, 4);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
